// File: rtl/spdif_tx_ext.sv
// rtl/spdif_tx_ext.sv - IEC 60958 consumer S/PDIF transmitter, 16..24-bit samples
module spdif_tx_ext #(
  parameter int SAMPLE_W      = 16,
  parameter bit UNDERRUN_MUTE = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                bit_en_i,
  input  logic                sample_valid_i,
  output logic                sample_ready_o,
  input  logic [SAMPLE_W-1:0] sample_l_i,
  input  logic [SAMPLE_W-1:0] sample_r_i,
  input  logic                cs_copy_i,
  input  logic [3:0]          cs_fs_i,
  output logic                spdif_o,
  output logic                block_start_o,
  output logic                underrun_o
);

  typedef enum logic {SF_A = 1'b0, SF_B = 1'b1} sf_e;

  localparam int         PAD_W = 24 - SAMPLE_W;
  localparam logic [7:0] PRE_B = 8'b00010111;
  localparam logic [7:0] PRE_M = 8'b01000111;
  localparam logic [7:0] PRE_W = 8'b00100111;

  sf_e                 r_sf;
  sf_e                 w_sf_next;
  logic [5:0]          r_half;
  logic                r_load;
  logic [7:0]          r_frame;
  logic                r_full;
  logic                r_ready;
  logic                r_armed;
  logic [SAMPLE_W-1:0] r_buf_l;
  logic [SAMPLE_W-1:0] r_buf_r;
  logic [SAMPLE_W-1:0] r_smp_l;
  logic [SAMPLE_W-1:0] r_smp_r;
  logic                r_v;
  logic                r_cs_copy;
  logic [3:0]          r_cs_fs;
  logic [7:0]          r_pre;
  logic [31:0]         r_data;
  logic                r_spdif;
  logic                r_block_start;
  logic                r_underrun;

  logic                w_accept;
  logic                w_load_a;
  logic                w_under;
  logic                w_full_next;
  logic [SAMPLE_W-1:0] w_smp;
  logic                w_v;
  logic                w_c;
  logic [23:0]         w_aud;
  logic [31:0]         w_word;
  logic [7:0]          w_pre;

  assign w_accept    = sample_valid_i & r_ready;
  assign w_load_a    = r_load & (r_sf == SF_A);
  assign w_under     = w_load_a & ~r_full;
  // A same-clock accept only happens with the buffer empty, so the load never loses a pair.
  assign w_full_next = w_accept | (r_full & ~w_load_a);

  assign sample_ready_o = r_ready;
  assign spdif_o        = r_spdif;
  assign block_start_o  = r_block_start;
  assign underrun_o     = r_underrun;

  // Half-bit slot counter; the 63->0 wrap schedules the next subframe load one clk later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_half <= '0;
      r_load <= 1'b1;
    end else begin
      if (r_load) r_load <= 1'b0;
      if (bit_en_i) begin
        r_half <= r_half + 6'd1;
        if (r_half == 6'd63) r_load <= 1'b1;
      end
    end
  end

  // Subframe A/B state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sf <= SF_A;
    else         r_sf <= w_sf_next;
  end

  // Subframe next-state: alternate A and B on every load
  always_comb begin
    w_sf_next = r_sf;
    if (r_load) w_sf_next = (r_sf == SF_A) ? SF_B : SF_A;
  end

  // Build the 32-slot word and preamble for the subframe about to load
  always_comb begin
    w_smp = r_smp_r;
    w_v   = r_v;
    if (r_sf == SF_A) begin
      w_v = ~r_full & UNDERRUN_MUTE;
      if (r_full)             w_smp = r_buf_l;
      else if (UNDERRUN_MUTE) w_smp = '0;
      else                    w_smp = r_smp_l;
    end
    w_c = 1'b0;
    if (r_frame == 8'd2)                           w_c = r_cs_copy;
    else if (r_frame >= 8'd24 && r_frame <= 8'd27) w_c = r_cs_fs[r_frame[1:0]];
    w_aud  = 24'(w_smp) << PAD_W;
    w_word = {^{w_c, w_v, w_aud}, w_c, 1'b0, w_v, w_aud, 4'b0000};
    if (r_sf == SF_B)         w_pre = PRE_W;
    else if (r_frame == 8'd0) w_pre = PRE_B;
    else                      w_pre = PRE_M;
    // Keep preamble polarity relative to the level left by the previous subframe.
    if (r_spdif) w_pre = ~w_pre;
  end

  // One-pair input buffer with registered ready and underrun arming
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full  <= 1'b0;
      r_ready <= 1'b0;
      r_armed <= 1'b0;
      r_buf_l <= '0;
      r_buf_r <= '0;
    end else begin
      r_full  <= w_full_next;
      r_ready <= ~w_full_next;
      if (w_accept) begin
        r_armed <= 1'b1;
        r_buf_l <= sample_l_i;
        r_buf_r <= sample_r_i;
      end
    end
  end

  // Subframe loader: frame counter, held pair, channel status latch, status pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame       <= '0;
      r_smp_l       <= '0;
      r_smp_r       <= '0;
      r_v           <= 1'b0;
      r_cs_copy     <= 1'b0;
      r_cs_fs       <= '0;
      r_pre         <= '0;
      r_data        <= '0;
      r_block_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_block_start <= w_load_a & (r_frame == 8'd0);
      r_underrun    <= w_under & r_armed;
      if (r_load) begin
        r_pre  <= w_pre;
        r_data <= w_word;
        if (r_sf == SF_B) begin
          r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;
        end else begin
          r_v <= w_v;
          if (r_full) begin
            r_smp_l <= r_buf_l;
            r_smp_r <= r_buf_r;
          end else if (UNDERRUN_MUTE) begin
            r_smp_l <= '0;
            r_smp_r <= '0;
          end
          if (r_frame == 8'd0) begin
            r_cs_copy <= cs_copy_i;
            r_cs_fs   <= cs_fs_i;
          end
        end
      end
    end
  end

  // BMC line driver: preamble half-bits verbatim, data slots toggle first half, ones toggle again
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_spdif <= 1'b0;
    end else if (bit_en_i) begin
      if (r_half < 6'd8)   r_spdif <= r_pre[r_half[2:0]];
      else if (!r_half[0]) r_spdif <= ~r_spdif;
      else                 r_spdif <= r_spdif ^ r_data[r_half[5:1]];
    end
  end

endmodule
